// File: rtl/i2c_byte_gen_pkg.sv
// Shared types for the I2C bit-level byte engine: FSM states, bit phases,
// the registered state struct and the SDA drive rule.
package i2c_byte_gen_pkg;

    typedef enum logic [1:0] {BG_IDLE, BG_BIT, BG_DONE} t_byte_gen_states;
    typedef enum logic [1:0] {P0, P1, P2, P3} t_bit_phase;

    localparam logic [3:0] ACK_BIT = 4'd8;

    typedef struct packed {
        t_byte_gen_states st;
        t_bit_phase       ph;
        logic [3:0]       bit_cnt;
        logic             we;
        logic             last;
        logic [7:0]       tx;
        logic [7:0]       rx;
        logic             ack;
        logic [7:0]       rd_byte;
        logic             scl_hold;
    } t_bg_state;

    // SDA pull-down for the current bit: data bits MSB-first on writes,
    // released for the slave's ACK; on reads ACK unless this is the last byte.
    function automatic logic sda_drive(input logic we, input logic last,
                                       input logic [3:0] bit_cnt, input logic [7:0] tx);
        if (bit_cnt[3]) return we ? 1'b0 : ~last;
        return we ? ~tx[~bit_cnt[2:0]] : 1'b0;
    endfunction

endpackage

// File: rtl/i2c_byte_gen_sync.sv
// Two-flop synchronizer for the SCL/SDA pad inputs; idles high like a released bus.
module i2c_sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/i2c_byte_gen.sv
// Bit-level I2C byte engine: shifts one byte plus ACK/NACK over open-drain
// SCL/SDA enables, with SCL clock stretching honoured in the high phase.
module i2c_byte_gen
    import i2c_byte_gen_pkg::*;
#(
    parameter  int QUARTER_PERIOD = 62,
    localparam int CNT_WIDTH      = $clog2(QUARTER_PERIOD + 1)
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_req_valid,
    input  logic       i_req_we,
    input  logic       i_req_last_byte,
    input  logic [7:0] i_wr_byte,
    output logic       o_ready,
    output logic       o_wr_ack,
    output logic       o_wr_nack,
    output logic       o_rd_valid,
    output logic [7:0] o_rd_byte,
    input  logic       i_scl_in,
    input  logic       i_sda_in,
    output logic       o_scl_oe,
    output logic       o_sda_oe
);
    t_bg_state r, n;
    logic [CNT_WIDTH-1:0] cnt, cnt_n;
    logic scl_s, sda_s, phase_end;

    i2c_sync_2ff u_scl_sync (.clk(i_clk), .rst_n(i_rst_n), .d(i_scl_in), .q(scl_s));
    i2c_sync_2ff u_sda_sync (.clk(i_clk), .rst_n(i_rst_n), .d(i_sda_in), .q(sda_s));

    assign phase_end = (cnt == CNT_WIDTH'(QUARTER_PERIOD - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r   <= '0;
            cnt <= '0;
        end else begin
            r   <= n;
            cnt <= cnt_n;
        end
    end

    always_comb begin
        n     = r;
        cnt_n = cnt;
        case (r.st)
            BG_IDLE: begin
                if (i_req_valid) begin
                    n.st      = BG_BIT;
                    n.ph      = P0;
                    n.bit_cnt = '0;
                    n.we      = i_req_we;
                    n.last    = i_req_last_byte;
                    n.tx      = i_wr_byte;
                    cnt_n     = '0;
                end
            end
            BG_BIT: begin
                case (r.ph)
                    P0, P1: begin
                        if (phase_end) begin
                            n.ph  = (r.ph == P0) ? P1 : P2;
                            cnt_n = '0;
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    P2: begin
                        // Only count once SCL is seen high: a slave holding it low stretches this phase.
                        if (scl_s) begin
                            if (phase_end) begin
                                n.ph  = P3;
                                cnt_n = '0;
                                if (r.bit_cnt == ACK_BIT) n.ack = sda_s;
                                else                      n.rx  = {r.rx[6:0], sda_s};
                            end else begin
                                cnt_n = cnt + 1'b1;
                            end
                        end
                    end
                    P3: begin
                        if (phase_end) begin
                            cnt_n = '0;
                            if (r.bit_cnt == ACK_BIT) begin
                                n.st       = BG_DONE;
                                n.scl_hold = 1'b1;
                                if (!r.we) n.rd_byte = r.rx;
                            end else begin
                                n.bit_cnt = r.bit_cnt + 4'd1;
                                n.ph      = P0;
                            end
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                endcase
            end
            BG_DONE: n.st = BG_IDLE;
            default: n.st = BG_IDLE;
        endcase
    end

    // SCL stays pulled low between bytes so the start/stop generators can take over cleanly.
    assign o_scl_oe   = (r.st == BG_BIT) ? (r.ph == P0 || r.ph == P1) : r.scl_hold;
    assign o_sda_oe   = (r.st == BG_BIT) && sda_drive(r.we, r.last, r.bit_cnt, r.tx);
    assign o_ready    = (r.st == BG_IDLE);
    assign o_wr_ack   = (r.st == BG_DONE) &&  r.we && !r.ack;
    assign o_wr_nack  = (r.st == BG_DONE) &&  r.we &&  r.ack;
    assign o_rd_valid = (r.st == BG_DONE) && !r.we;
    assign o_rd_byte  = r.rd_byte;

endmodule
